// File: rtl/tdc_pkg.sv
// tdc_pkg: control FSM encodings and default geometry shared by the TDC core
// and the readout/register block.
`timescale 1ns/1ps
package tdc_pkg;

  localparam int unsigned TDC_TAPS     = 32;
  localparam int unsigned TDC_COARSE_W = 16;
  localparam int unsigned TDC_FINE_W   = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/tdc_tap_capture.sv
// tdc_tap_capture: one event input -> tapped delay line -> clk snapshot.
//   clk, rst_n : sampling clock, async active-low reset
//   event_in   : asynchronous event (rising edge is measured)
//   detect     : snapshot tap0 rose since the previous snapshot (registered)
//   fine       : ones-count of the snapshot, 0..TAPS (registered)
//   sat        : fine == TAPS (registered)
`timescale 1ns/1ps
module tdc_tap_capture #(
  parameter int unsigned TAPS   = 32,
  parameter int unsigned FINE_W = 6
`ifdef TDC_SIM
  , parameter real TAP_DLY = 0.5
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              event_in,
  output logic              detect,
  output logic [FINE_W-1:0] fine,
  output logic              sat
);

  logic [TAPS-1:0]   taps;
  logic [TAPS-1:0]   snap;
  logic              prev_tap0;
  logic [FINE_W-1:0] ones_c;

  // Delay line: one kept buffer cell per tap, each tap delayed from the previous one.
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    (* keep = "true" *) logic t;
    if (i == 0) begin : g_first
`ifdef TDC_SIM
      assign #(TAP_DLY) t = event_in;
`else
      assign t = event_in;
`endif
    end else begin : g_next
`ifdef TDC_SIM
      assign #(TAP_DLY) t = g_tap[i-1].t;
`else
      assign t = g_tap[i-1].t;
`endif
    end
    assign taps[i] = t;
  end

  // Population count tolerates bubbles in the thermometer code.
  always_comb begin
    ones_c = '0;
    for (int i = 0; i < TAPS; i++) begin
      ones_c = ones_c + FINE_W'(snap[i]);
    end
  end

  // Snapshot and decode stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      prev_tap0 <= 1'b0;
      detect    <= 1'b0;
      fine      <= '0;
      sat       <= 1'b0;
    end else begin
      snap      <= taps;
      prev_tap0 <= snap[0];
      detect    <= snap[0] & ~prev_tap0;
      fine      <= ones_c;
      sat       <= (ones_c == FINE_W'(TAPS));
    end
  end

endmodule

// File: rtl/tdc_multistop.sv
// tdc_multistop: one start channel timed against N_STOP stop channels.
//   clk, rst_n      : sampling clock, async active-low reset
//   enable, arm     : block enable (low aborts to IDLE), one-shot arm request
//   start_in        : asynchronous start event
//   stop_in         : asynchronous stop events, one per channel
//   busy            : measurement in progress (ARMED, RUN, DRAIN)
//   res_valid/ready : result handshake, one result per channel in ascending order
//   res_channel, res_coarse, res_fine_start, res_fine_stop, res_timeout, res_sat
`timescale 1ns/1ps
module tdc_multistop
  import tdc_pkg::*;
#(
  parameter int unsigned TAPS     = TDC_TAPS,
  parameter int unsigned N_STOP   = 2,
  parameter int unsigned COARSE_W = TDC_COARSE_W,
  parameter int unsigned FINE_W   = TDC_FINE_W,
  parameter int unsigned CH_W     = 1
`ifdef TDC_SIM
  , parameter real TAP_DLY = 0.5
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                arm,
  input  logic                start_in,
  input  logic [N_STOP-1:0]   stop_in,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_W-1:0]     res_channel,
  output logic [COARSE_W-1:0] res_coarse,
  output logic [FINE_W-1:0]   res_fine_start,
  output logic [FINE_W-1:0]   res_fine_stop,
  output logic                res_timeout,
  output logic                res_sat
);

  localparam logic [COARSE_W-1:0] MAX_COARSE = '1;

  logic              start_det;
  logic [FINE_W-1:0] start_fine;
  logic              start_fsat;
  logic [N_STOP-1:0] stop_det;
  logic [FINE_W-1:0] stop_fine [N_STOP];
  logic [N_STOP-1:0] stop_fsat;

  tdc_tap_capture #(
    .TAPS   (TAPS),
    .FINE_W (FINE_W)
`ifdef TDC_SIM
    , .TAP_DLY(TAP_DLY)
`endif
  ) u_start_cap (
    .clk      (clk),
    .rst_n    (rst_n),
    .event_in (start_in),
    .detect   (start_det),
    .fine     (start_fine),
    .sat      (start_fsat)
  );

  for (genvar i = 0; i < N_STOP; i++) begin : g_stop
    tdc_tap_capture #(
      .TAPS   (TAPS),
      .FINE_W (FINE_W)
`ifdef TDC_SIM
      , .TAP_DLY(TAP_DLY)
`endif
    ) u_stop_cap (
      .clk      (clk),
      .rst_n    (rst_n),
      .event_in (stop_in[i]),
      .detect   (stop_det[i]),
      .fine     (stop_fine[i]),
      .sat      (stop_fsat[i])
    );
  end

  logic [1:0]          state, state_d;
  logic [COARSE_W-1:0] coarse, coarse_d, coarse_inc;
  logic [N_STOP-1:0]   hit, hit_d;
  logic [COARSE_W-1:0] hit_coarse [N_STOP];
  logic [COARSE_W-1:0] hit_coarse_d [N_STOP];
  logic [FINE_W-1:0]   hit_fine [N_STOP];
  logic [FINE_W-1:0]   hit_fine_d [N_STOP];
  logic [N_STOP-1:0]   hit_sat, hit_sat_d;
  logic [FINE_W-1:0]   fs, fs_d;
  logic                fs_sat, fs_sat_d;
  logic [CH_W-1:0]     ch_idx, ch_d;
  logic                load;
  logic [CH_W-1:0]     ld_idx;
  logic                busy_d, valid_d, timeout_d, sat_d;
  logic [CH_W-1:0]     channel_d;
  logic [COARSE_W-1:0] res_coarse_d;
  logic [FINE_W-1:0]   fine_start_d, fine_stop_d;

  // Next-state, stop latching and result-register loading.
  always_comb begin
    state_d      = state;
    coarse_d     = coarse;
    hit_d        = hit;
    hit_coarse_d = hit_coarse;
    hit_fine_d   = hit_fine;
    hit_sat_d    = hit_sat;
    fs_d         = fs;
    fs_sat_d     = fs_sat;
    ch_d         = ch_idx;
    load         = 1'b0;
    ld_idx       = '0;
    valid_d      = res_valid;
    channel_d    = res_channel;
    res_coarse_d = res_coarse;
    fine_start_d = res_fine_start;
    fine_stop_d  = res_fine_stop;
    timeout_d    = res_timeout;
    sat_d        = res_sat;
    coarse_inc   = (coarse == MAX_COARSE) ? coarse : coarse + COARSE_W'(1);

    case (state)
      ST_IDLE: begin
        if (arm && enable) begin
          state_d  = ST_ARMED;
          coarse_d = '0;
          hit_d    = '0;
        end
      end
      ST_ARMED: begin
        if (start_det) begin
          state_d  = ST_RUN;
          coarse_d = '0;
          fs_d     = start_fine;
          fs_sat_d = start_fsat;
        end
      end
      ST_RUN: begin
        coarse_d = coarse_inc;
        // A stop seen in this cycle belongs to the incremented count.
        for (int i = 0; i < N_STOP; i++) begin
          if (stop_det[i] && !hit[i]) begin
            hit_d[i]        = 1'b1;
            hit_coarse_d[i] = coarse_inc;
            hit_fine_d[i]   = stop_fine[i];
            hit_sat_d[i]    = stop_fsat[i];
          end
        end
        if ((&hit) || (coarse == MAX_COARSE)) begin
          state_d = ST_DRAIN;
          ch_d    = '0;
          load    = 1'b1;
          ld_idx  = '0;
        end
      end
      ST_DRAIN: begin
        if (res_valid && res_ready) begin
          if (ch_idx == CH_W'(N_STOP - 1)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            ch_d   = ch_idx + CH_W'(1);
            load   = 1'b1;
            ld_idx = ch_idx + CH_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Missed channels report a saturated count with no stop fine value.
    if (load) begin
      valid_d      = 1'b1;
      channel_d    = ld_idx;
      fine_start_d = fs;
      timeout_d    = ~hit_d[ld_idx];
      res_coarse_d = hit_d[ld_idx] ? hit_coarse_d[ld_idx] : MAX_COARSE;
      fine_stop_d  = hit_d[ld_idx] ? hit_fine_d[ld_idx] : '0;
      sat_d        = fs_sat | (hit_d[ld_idx] & hit_sat_d[ld_idx]);
    end

    if (!enable) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      hit_d   = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      coarse         <= '0;
      hit            <= '0;
      hit_sat        <= '0;
      fs             <= '0;
      fs_sat         <= 1'b0;
      ch_idx         <= '0;
      for (int i = 0; i < N_STOP; i++) begin
        hit_coarse[i] <= '0;
        hit_fine[i]   <= '0;
      end
      busy           <= 1'b0;
      res_valid      <= 1'b0;
      res_channel    <= '0;
      res_coarse     <= '0;
      res_fine_start <= '0;
      res_fine_stop  <= '0;
      res_timeout    <= 1'b0;
      res_sat        <= 1'b0;
    end else begin
      state          <= state_d;
      coarse         <= coarse_d;
      hit            <= hit_d;
      hit_sat        <= hit_sat_d;
      fs             <= fs_d;
      fs_sat         <= fs_sat_d;
      ch_idx         <= ch_d;
      hit_coarse     <= hit_coarse_d;
      hit_fine       <= hit_fine_d;
      busy           <= busy_d;
      res_valid      <= valid_d;
      res_channel    <= channel_d;
      res_coarse     <= res_coarse_d;
      res_fine_start <= fine_start_d;
      res_fine_stop  <= fine_stop_d;
      res_timeout    <= timeout_d;
      res_sat        <= sat_d;
    end
  end

endmodule
